// File: rtl/bitsel_pkg.sv
// Shared types and default geometry for the bit-select readout slice.
// The FSM state is a plain logic vector with named constants so older tools see the same encoding.
package bitsel_pkg;

  localparam int VEC_W  = 1024;
  localparam int WORD_W = 16;
  localparam int NWORDS = VEC_W / WORD_W;
  localparam int IDX_W  = $clog2(NWORDS);

  typedef logic [0:0] state_t;

  localparam state_t IDLE = 1'b0;
  localparam state_t SEND = 1'b1;

endpackage

// File: rtl/bitsel_word_mux.sv
// Picks one WORD_W slice of the shadow vector by word index; word 0 is the LSBs.
// Purely combinational: zero latency, no flow control of its own.
module bitsel_word_mux
  import bitsel_pkg::*;
#(
  parameter  int VEC_W  = bitsel_pkg::VEC_W,
  parameter  int WORD_W = bitsel_pkg::WORD_W,
  parameter  int IDX_W  = bitsel_pkg::IDX_W,
  localparam int NWORDS = VEC_W / WORD_W
) (
  input  logic [VEC_W-1:0]  shadow,
  input  logic [IDX_W-1:0]  idx,
  output logic [WORD_W-1:0] word
);

  logic [NWORDS-1:0][WORD_W-1:0] words;

  assign words = shadow;
  assign word  = words[idx];

endmodule

// File: rtl/bitsel_readout.sv
// Snapshots a wide bit vector on req_i and streams it out LSB word first; optional parity via READOUT_PARITY_EN.
// Latency: first word valid one cycle after the capturing edge; done_o one cycle after the last accepted word.
// Backpressure: valid/ready; word outputs hold while ready is low, req_i is ignored while busy.
module bitsel_readout
  import bitsel_pkg::*;
#(
  parameter  int VEC_W  = bitsel_pkg::VEC_W,
  parameter  int WORD_W = bitsel_pkg::WORD_W,
  localparam int NWORDS = VEC_W / WORD_W,
  localparam int IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [VEC_W-1:0]  vec_i,
  input  logic              req_i,
  output logic              busy_o,
  output logic              word_valid_o,
  input  logic              word_ready_i,
  output logic [WORD_W-1:0] word_data_o,
  output logic [IDX_W-1:0]  word_idx_o,
  output logic              word_last_o,
  output logic              word_par_o,
  output logic              done_o
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

  state_t            state;
  logic [IDX_W-1:0]  idx;
  logic [VEC_W-1:0]  shadow;
  logic              done_q;
  logic [WORD_W-1:0] mux_word;
  logic              sending;
  logic              xfer;
  logic              at_last;

  assign sending = (state == SEND);
  assign xfer    = sending & word_ready_i;
  assign at_last = (idx == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      idx    <= '0;
      shadow <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (!sending) begin
        if (req_i) begin
          shadow <= vec_i;
          idx    <= '0;
          state  <= SEND;
        end
      end else if (xfer) begin
        if (at_last) begin
          // idx parks at 0 so the idle index output matches the reset value
          state  <= IDLE;
          idx    <= '0;
          done_q <= 1'b1;
        end else begin
          idx <= idx + 1'b1;
        end
      end
    end
  end

  bitsel_word_mux #(
    .VEC_W  (VEC_W),
    .WORD_W (WORD_W),
    .IDX_W  (IDX_W)
  ) u_word_mux (
    .shadow (shadow),
    .idx    (idx),
    .word   (mux_word)
  );

  assign busy_o       = sending;
  assign word_valid_o = sending;
  assign word_idx_o   = idx;
  assign word_last_o  = sending & at_last;
  assign done_o       = done_q;
  // Data is blanked outside SEND so a stale snapshot never leaks onto the bus.
  assign word_data_o  = sending ? mux_word : '0;

`ifdef READOUT_PARITY_EN
  assign word_par_o = ^word_data_o;
`else
  assign word_par_o = 1'b0;
`endif

endmodule

// File: tb/tb_bitsel_readout.sv
// Randomized scoreboard bench for bitsel_readout: a queue-based model predicts every streamed word.
module tb_bitsel_readout;

  localparam int VW = 1024;
  localparam int WW = 16;
  localparam int NW = VW / WW;
  localparam int IW = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [VW-1:0] vec_i;
  logic          req_i;
  logic          busy_o;
  logic          word_valid_o;
  logic          word_ready_i;
  logic [WW-1:0] word_data_o;
  logic [IW-1:0] word_idx_o;
  logic          word_last_o;
  logic          word_par_o;
  logic          done_o;

  bitsel_readout #(.VEC_W(VW), .WORD_W(WW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .vec_i        (vec_i),
    .req_i        (req_i),
    .busy_o       (busy_o),
    .word_valid_o (word_valid_o),
    .word_ready_i (word_ready_i),
    .word_data_o  (word_data_o),
    .word_idx_o   (word_idx_o),
    .word_last_o  (word_last_o),
    .word_par_o   (word_par_o),
    .done_o       (done_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WW-1:0] d;
    logic [IW-1:0] i;
    logic          l;
  } exp_t;

  exp_t q[$];
  bit   m_busy;
  int   m_left;
  bit   exp_done;
  int   nxfer;
  int   total = 0;
  int   bad = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [VW-1:0] rnd_vec();
    logic [VW-1:0] v;
    for (int k = 0; k < VW / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  // Reference model: a capture enqueues all words of the snapshot; each accepted word retires one.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_busy   = 1'b0;
      m_left   = 0;
      exp_done = 1'b0;
    end else begin
      exp_done = 1'b0;
      if (m_busy) begin
        if (word_ready_i) begin
          m_left--;
          if (m_left == 0) begin
            m_busy   = 1'b0;
            exp_done = 1'b1;
          end
        end
      end else if (req_i) begin
        for (int w = 0; w < NW; w++) begin
          exp_t e;
          e.d = WW'(vec_i >> (w * WW));
          e.i = IW'(w);
          e.l = (w == NW - 1);
          q.push_back(e);
        end
        m_busy = 1'b1;
        m_left = NW;
      end
    end
  end

  // Monitor: compares the presented word to the queue head every cycle; pops on handshake.
  always @(negedge clk) begin
    logic exp_par;
    check("busy", busy_o, m_busy);
    check("valid", word_valid_o, m_busy);
    check("done", done_o, exp_done);
    if (word_valid_o) begin
      if (q.size() == 0) begin
        check("unexpected_word", 1, 0);
      end else begin
`ifdef READOUT_PARITY_EN
        exp_par = ^q[0].d;
`else
        exp_par = 1'b0;
`endif
        check("data", word_data_o, q[0].d);
        check("idx", word_idx_o, q[0].i);
        check("last", word_last_o, q[0].l);
        check("par", word_par_o, exp_par);
        if (word_ready_i) begin
          void'(q.pop_front());
          nxfer++;
        end
      end
    end else begin
      check("last_idle", word_last_o, 0);
      check("par_idle", word_par_o, 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string nm, input int max);
    bit ok = 1'b0;
    for (int k = 0; k < max; k++) begin
      tick();
      if (done_o) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check({nm, "_done_timeout"}, 0, 1);
  endtask

  task automatic wait_idx(input string nm, input int target, input int max);
    bit ok = 1'b0;
    for (int k = 0; k < max; k++) begin
      tick();
      if (word_valid_o && word_idx_o == IW'(target)) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check({nm, "_idx_timeout"}, 0, 1);
  endtask

  task automatic start(input logic [VW-1:0] v);
    vec_i = v;
    req_i = 1'b1;
    tick();
    req_i = 1'b0;
  endtask

  initial begin
    int n;
    int base;
    logic [VW-1:0] v;
    nxfer        = 0;
    rst_n        = 1'b0;
    req_i        = 1'b0;
    word_ready_i = 1'b0;
    vec_i        = '0;
    #3;
    check("rst_valid", word_valid_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_last", word_last_o, 0);
    check("rst_data", word_data_o, 0);
    check("rst_idx", word_idx_o, 0);
    check("rst_par", word_par_o, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Full stream with ready held high: 64 consecutive words, done one cycle after the last.
    v = rnd_vec();
    v[15:0]      = 16'hA5A5;
    v[1023:1008] = 16'h1234;
    vec_i = v;
    word_ready_i = 1'b1;
    req_i = 1'b1;
    n = 0;
    for (int k = 0; k < 200; k++) begin
      tick();
      n++;
      if (n == 1) begin
        req_i = 1'b0;
        check("t1_first_valid", word_valid_o, 1);
        check("t1_word0", word_data_o, 16'hA5A5);
      end
      if (n == 64) begin
        check("t1_word63", word_data_o, 16'h1234);
        check("t1_last63", word_last_o, 1);
      end
      if (done_o) break;
    end
    check("t1_done_latency", n, 65);
    tick();
    check("t1_done_one_cycle", done_o, 0);

    // Stall at index 10.
    start(rnd_vec());
    wait_idx("t2", 10, 100);
    word_ready_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("t2_stall_idx", word_idx_o, 10);
    end
    word_ready_i = 1'b1;
    tick();
    check("t2_resume_idx", word_idx_o, 11);
    wait_done("t2", 100);

    // Input changes after capture must not leak into the stream.
    vec_i = '0;
    req_i = 1'b1;
    tick();
    req_i = 1'b0;
    vec_i = '1;
    wait_done("t3", 100);

    // Ignored request mid-stream, then back-to-back request on the done cycle.
    base = nxfer;
    start(rnd_vec());
    wait_idx("t4", 30, 100);
    vec_i = rnd_vec();
    req_i = 1'b1;
    tick();
    req_i = 1'b0;
    wait_done("t4a", 100);
    check("t4_count_first", nxfer - base, 64);
    vec_i = rnd_vec();
    req_i = 1'b1;
    tick();
    req_i = 1'b0;
    check("t4_restart_busy", busy_o, 1);
    wait_done("t4b", 100);
    check("t4_count_total", nxfer - base, 128);

    // Reset mid-stream aborts without done.
    start(rnd_vec());
    wait_idx("t5", 20, 100);
    rst_n = 1'b0;
    #1;
    check("t5_valid", word_valid_o, 0);
    check("t5_busy", busy_o, 0);
    check("t5_idx", word_idx_o, 0);
    check("t5_done", done_o, 0);
    tick(); tick();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    check("t5_idle_after", busy_o, 0);

    // Parity patterns in words 0 and 1.
    v = rnd_vec();
    v[15:0]  = 16'h0001;
    v[31:16] = 16'h0003;
    start(v);
    wait_done("t6", 100);

    // Random traffic: random ready, random requests, random vectors.
    for (int k = 0; k < 1500; k++) begin
      word_ready_i = ($urandom_range(0, 3) != 0);
      req_i        = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0) vec_i = rnd_vec();
      tick();
    end
    req_i = 1'b0;
    word_ready_i = 1'b1;
    n = 0;
    while (busy_o && n < 200) begin
      tick();
      n++;
    end
    check("t7_drained", busy_o, 0);
    tick();
    check("queue_empty", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bitsel_readout.md
BITSEL_READOUT -- requirements
Module: bitsel_readout

Interface
REQ-001 SHALL have parameter VEC_W, default 1024: width of the snapshotted bit vector.
REQ-002 SHALL have parameter WORD_W, default 16: width of each streamed word; VEC_W SHALL be an integer multiple of WORD_W.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1: asynchronous, active-low reset.
REQ-005 SHALL have port vec_i  input  VEC_W: the dout vector of the upstream bit-select write stage.
REQ-006 SHALL have port req_i  input  1: snapshot-and-stream request, sampled only in IDLE.
REQ-007 SHALL have port busy_o  output  1: high in every state except IDLE.
REQ-008 SHALL have port word_valid_o  output  1: word_data_o holds a valid word.
REQ-009 SHALL have port word_ready_i  input  1: the consumer accepts the word.
REQ-010 SHALL have port word_data_o  output  WORD_W: the current word of the snapshot.
REQ-011 SHALL have port word_idx_o  output  log2(VEC_W/WORD_W): index of the current word (6 bits at the defaults).
REQ-012 SHALL have port word_last_o  output  1: the current word is the final word.
REQ-013 SHALL have port word_par_o  output  1: even parity of word_data_o (see Configuration).
REQ-014 SHALL have port done_o  output  1: one-cycle pulse after the final word is accepted.

Function
REQ-015 SHALL implement an FSM with two states: IDLE and SEND.
REQ-016 In IDLE with req_i=1, SHALL capture vec_i into the shadow register, clear the index to 0, and enter SEND on the same edge.
REQ-017 SHALL assert word_valid_o in the cycle after the capturing edge (1-cycle latency from req_i).
REQ-018 In SEND, word_valid_o SHALL be 1 and word_data_o SHALL equal shadow[idx*WORD_W +: WORD_W]; word 0 is the LSBs.
REQ-019 A transfer SHALL occur only on a cycle where word_valid_o and word_ready_i are both 1.
REQ-020 While valid=1 and ready=0, word_data_o, word_idx_o, word_last_o and word_par_o SHALL hold stable.
REQ-021 On a transfer with idx < last, SHALL increment idx by 1.
REQ-022 On a transfer with idx = last, SHALL return to IDLE and pulse done_o in the next cycle only.
REQ-023 word_last_o SHALL be 1 exactly when in SEND with idx = VEC_W/WORD_W-1.
REQ-024 req_i while busy SHALL be ignored, neither queued nor restarting the transfer.
REQ-025 Changes on vec_i after capture SHALL NOT affect the words being streamed.
REQ-026 req_i on the done_o cycle (already IDLE) SHALL start a new capture; back-to-back transfers are legal.
REQ-027 word_valid_o SHALL NOT depend combinationally on word_ready_i.

Reset
REQ-028 On rst_n=0, SHALL asynchronously force: state=IDLE, idx=0, shadow=0, busy_o=0, word_valid_o=0, word_last_o=0, done_o=0, word_data_o=0, word_par_o=0.
REQ-029 Reset asserted mid-SEND SHALL abort the stream without a done_o pulse; after release, the block waits in IDLE for a new req_i.

Configuration
REQ-030 With READOUT_PARITY_EN defined, word_par_o SHALL equal the XOR of word_data_o bits while valid, and 0 otherwise.
REQ-031 Without READOUT_PARITY_EN, word_par_o SHALL be tied to 0 and no parity logic SHALL be synthesized.

Structure
REQ-032 A shared package bitsel_pkg SHALL hold the state typedef (IDLE, SEND) and constants VEC_W=1024, WORD_W=16, NWORDS=64, IDX_W=6.
REQ-033 A sub-module bitsel_word_mux SHALL select one WORD_W slice from the shadow register by index; all other logic stays in one module.

Verification
REQ-034 With reset released, vec_i[15:0]=16'hA5A5 and vec_i[1023:1008]=16'h1234, pulse req_i with ready=1 held -> 64 words on consecutive cycles; word 0=A5A5; word 63=1234 with last=1; done_o pulses on the following cycle.
REQ-035 Stall: hold ready=0 for 5 cycles at idx 10 -> data and idx stay at 10 throughout; the stream resumes at 11 after ready=1.
REQ-036 Change vec_i to all ones immediately after capture of an all-zero vector -> all 64 words are 0.
REQ-037 Pulse req_i at idx 30 -> ignored; exactly 64 words total; req_i asserted on the done_o cycle starts a second stream.
REQ-038 Assert rst_n=0 at idx 20 -> valid, busy and idx clear immediately; no done_o pulse.
REQ-039 With READOUT_PARITY_EN defined, word 16'h0001 -> par=1 and word 16'h0003 -> par=0; without the macro, par=0 for all words.
